// File: rtl/koopa_anim_sequencer.sv
// Koopa animation sequencer.
// Tracks which animation is active and the current frame inside it. The frame
// steps forward once every TICKS_PER_FRAME display-frame ticks. Sprite-local
// pixel coordinates become koopa ROM addresses, with optional horizontal
// mirroring. rgb_valid_o is delayed by two cycles so that it lines up with the
// ROM's registered rgb output.
module koopa_anim_sequencer #(
    parameter int TICKS_PER_FRAME = 6,
    parameter int SPR_W           = 23,
    parameter int SPR_H           = 30,
    parameter int FRAME_PX        = 690
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_tick_i,
    input  logic [2:0]  anim_sel_i,
    input  logic        facing_left_i,
    input  logic        px_valid_i,
    input  logic [4:0]  px_x_i,
    input  logic [4:0]  px_y_i,
    output logic [13:0] rom_addr_o,
    output logic        rgb_valid_o,
    output logic [3:0]  frame_idx_o,
    output logic        busy_o,
    output logic        anim_done_o
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FRAME - 1);

    localparam logic [2:0] ANIM_IDLE  = 3'd0;
    localparam logic [2:0] ANIM_WALK  = 3'd1;
    localparam logic [2:0] ANIM_JUMP  = 3'd2;
    localparam logic [2:0] ANIM_SHELL = 3'd3;
    localparam logic [2:0] ANIM_HIT   = 3'd4;

    typedef enum logic [1:0] {
        ST_LOOP = 2'd0,
        ST_ONCE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // First ROM frame of each animation.
    function automatic logic [3:0] anim_start(input logic [2:0] a);
        logic [3:0] s;
        case (a)
            ANIM_IDLE:  s = 4'd0;
            ANIM_WALK:  s = 4'd2;
            ANIM_JUMP:  s = 4'd6;
            ANIM_SHELL: s = 4'd8;
            ANIM_HIT:   s = 4'd12;
            default:    s = 4'd0;
        endcase
        return s;
    endfunction

    // Offset of the last frame of each animation (length - 1).
    function automatic logic [1:0] anim_last(input logic [2:0] a);
        logic [1:0] l;
        case (a)
            ANIM_IDLE:  l = 2'd1;
            ANIM_WALK:  l = 2'd3;
            ANIM_JUMP:  l = 2'd1;
            ANIM_SHELL: l = 2'd3;
            ANIM_HIT:   l = 2'd1;
            default:    l = 2'd1;
        endcase
        return l;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    cur_anim_q, cur_anim_d;
    logic [1:0]    offset_q, offset_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          done_s;
    logic [2:0]    sel_s;
    logic          hit_lock_s;

    logic [3:0]    frame_idx_q;
    logic          busy_q;
    logic          anim_done_q;

    logic [4:0]    col_s;
    logic          in_range_s;
    logic [13:0]   addr_s;
    logic [13:0]   rom_addr_q;
    logic          valid1_q;
    logic          rgb_valid_q;

    // Requests 5-7 are treated as idle; a playing hit cannot be interrupted.
    always_comb begin
        if (anim_sel_i > ANIM_HIT) begin
            sel_s = ANIM_IDLE;
        end else begin
            sel_s = anim_sel_i;
        end
        hit_lock_s = (state_q == ST_ONCE) && (cur_anim_q == ANIM_HIT);
    end

    // Next-state logic: an animation switch takes priority over frame stepping.
    always_comb begin
        state_d    = state_q;
        cur_anim_d = cur_anim_q;
        offset_d   = offset_q;
        tick_d     = tick_q;
        done_s     = 1'b0;
        if (!hit_lock_s && (sel_s != cur_anim_q)) begin
            cur_anim_d = sel_s;
            offset_d   = 2'd0;
            tick_d     = '0;
            if ((sel_s == ANIM_JUMP) || (sel_s == ANIM_HIT)) begin
                state_d = ST_ONCE;
            end else begin
                state_d = ST_LOOP;
            end
        end else if (frame_tick_i && (state_q != ST_HOLD)) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                case (state_q)
                    ST_LOOP: begin
                        if (offset_q == anim_last(cur_anim_q)) begin
                            offset_d = 2'd0;
                        end else begin
                            offset_d = offset_q + 2'd1;
                        end
                    end
                    ST_ONCE: begin
                        if (cur_anim_q == ANIM_HIT) begin
                            // Stepping past the last hit frame returns to idle.
                            if (offset_q == anim_last(cur_anim_q)) begin
                                cur_anim_d = ANIM_IDLE;
                                offset_d   = 2'd0;
                                state_d    = ST_LOOP;
                                done_s     = 1'b1;
                            end else begin
                                offset_d = offset_q + 2'd1;
                            end
                        end else begin
                            // Jump parks on its last frame.
                            offset_d = offset_q + 2'd1;
                            if ((offset_q + 2'd1) == anim_last(cur_anim_q)) begin
                                state_d = ST_HOLD;
                                done_s  = 1'b1;
                            end else begin
                                state_d = ST_ONCE;
                            end
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            tick_d = tick_q;
        end
    end

    // Animation state registers and their registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_LOOP;
            cur_anim_q  <= ANIM_IDLE;
            offset_q    <= 2'd0;
            tick_q      <= '0;
            frame_idx_q <= 4'd0;
            busy_q      <= 1'b0;
            anim_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_anim_q  <= cur_anim_d;
            offset_q    <= offset_d;
            tick_q      <= tick_d;
            frame_idx_q <= anim_start(cur_anim_d) + {2'b00, offset_d};
            busy_q      <= (state_d == ST_ONCE) && (cur_anim_d == ANIM_HIT);
            anim_done_q <= done_s;
        end
    end

    // Pixel address: frame base + row base + (possibly mirrored) column.
    always_comb begin
        if (facing_left_i) begin
            col_s = 5'(SPR_W - 1) - px_x_i;
        end else begin
            col_s = px_x_i;
        end
        in_range_s = px_valid_i && (px_x_i < 5'(SPR_W)) && (px_y_i < 5'(SPR_H));
        if (in_range_s) begin
            addr_s = (14'(frame_idx_q) * 14'(FRAME_PX))
                   + (14'(px_y_i) * 14'(SPR_W))
                   + 14'(col_s);
        end else begin
            addr_s = 14'd0;
        end
    end

    // Address stage and the two-deep valid pipeline matching ROM latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rom_addr_q  <= 14'd0;
            valid1_q    <= 1'b0;
            rgb_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= addr_s;
            valid1_q    <= in_range_s;
            rgb_valid_q <= valid1_q;
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign rgb_valid_o = rgb_valid_q;
    assign frame_idx_o = frame_idx_q;
    assign busy_o      = busy_q;
    assign anim_done_o = anim_done_q;

endmodule
